// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//
// Program-load controller for the easy6502 system. Bytes arriving from the
// UART receiver are written sequentially into program RAM starting at
// LOAD_BASE. While a load is in progress the 6502 is held in reset and the
// loader owns the RAM write port. After IDLE_CYCLES clocks with no received
// byte, the CPU is released, so a program streamed over serial starts running
// on its own. Any byte received outside LOAD starts a fresh load, which also
// covers reloading a running program.
//
// Optional feature macro: LOADER_VECTOR_EN
//   When defined, the loader writes LOAD_BASE into the 6502 reset vector
//   ($FFFC/$FFFD) after the idle timeout and before releasing the CPU.
//   When undefined, the reset vector must come from RAM initialisation.
//
// Ports:
//   clk          in   system clock; all logic is on its rising edge
//   resetn       in   asynchronous active-low reset
//   rx_data      in   received byte, valid with rx_valid
//   rx_valid     in   one-cycle strobe per received byte
//   rx_err       in   framing error, qualified by rx_valid
//   mem_addr     out  RAM write address (registered)
//   mem_wdata    out  RAM write data (registered)
//   mem_we       out  one-cycle RAM write strobe (registered)
//   loading      out  high in LOAD/VEC/RELEASE; RAM port belongs to the loader
//   cpu_reset_n  out  CPU reset, active-low
//   load_len     out  bytes written in the current or last load
//   load_err     out  sticky error flag for the current load
//
// Parameter constraint: LOAD_BASE + MAX_LEN <= 17'h10000 (pointer never wraps).

module uart_prog_loader #(
  parameter logic [15:0] LOAD_BASE   = 16'h0600,
  parameter logic [15:0] MAX_LEN     = 16'h0A00,
  parameter int          IDLE_CYCLES = 250000,
  parameter int          RST_HOLD    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        loading,
  output logic        cpu_reset_n,
  output logic [15:0] load_len,
  output logic        load_err
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD,
`ifdef LOADER_VECTOR_EN
    S_VEC,
`endif
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            state;
  logic [15:0]       ptr;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;
`ifdef LOADER_VECTOR_EN
  logic              vec_step;
`endif

  // A byte seen in any state other than LOAD begins a new load. The byte is
  // then processed against a freshly cleared pointer/length/error rather than
  // the values left over from the previous load.
  logic        start_new;
  logic [15:0] cur_ptr;
  logic [15:0] cur_len;
  logic        cur_err;

  always_comb begin
    start_new = (state != S_LOAD);
    cur_ptr   = start_new ? LOAD_BASE : ptr;
    cur_len   = start_new ? 16'h0000 : load_len;
    cur_err   = start_new ? 1'b0 : load_err;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_WAIT;
      ptr         <= LOAD_BASE;
      idle_cnt    <= '0;
      hold_cnt    <= '0;
`ifdef LOADER_VECTOR_EN
      vec_step    <= 1'b0;
`endif
      mem_addr    <= LOAD_BASE;
      mem_wdata   <= 8'h00;
      mem_we      <= 1'b0;
      loading     <= 1'b0;
      cpu_reset_n <= 1'b0;
      load_len    <= 16'h0000;
      load_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (rx_valid) begin
        // A received byte takes priority over the idle timeout and aborts any
        // pending vector writes or reset hold.
        state       <= S_LOAD;
        loading     <= 1'b1;
        cpu_reset_n <= 1'b0;
        idle_cnt    <= '0;
        if (rx_err || (cur_len == MAX_LEN)) begin
          // Dropped byte: the address stays where it was.
          ptr      <= cur_ptr;
          load_len <= cur_len;
          load_err <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= cur_ptr;
          mem_wdata <= rx_data;
          ptr       <= cur_ptr + 16'h0001;
          load_len  <= cur_len + 16'h0001;
          load_err  <= cur_err;
        end
      end else begin
        case (state)
          S_WAIT: ;

          S_LOAD: begin
            if (idle_cnt == IDLE_LAST) begin
`ifdef LOADER_VECTOR_EN
              state    <= S_VEC;
              vec_step <= 1'b0;
`else
              state    <= S_RELEASE;
              hold_cnt <= '0;
`endif
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end

`ifdef LOADER_VECTOR_EN
          // Point the 6502 reset vector at the loaded program, low byte first.
          // These writes are not counted in load_len.
          S_VEC: begin
            mem_we <= 1'b1;
            if (!vec_step) begin
              mem_addr  <= 16'hFFFC;
              mem_wdata <= LOAD_BASE[7:0];
              vec_step  <= 1'b1;
            end else begin
              mem_addr  <= 16'hFFFD;
              mem_wdata <= LOAD_BASE[15:8];
              state     <= S_RELEASE;
              hold_cnt  <= '0;
            end
          end
`endif

          S_RELEASE: begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= S_RUN;
              loading     <= 1'b0;
              cpu_reset_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end

          S_RUN: ;

          default: state <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Program-load controller for the easy6502 system. Takes received bytes from the UART receiver and writes them sequentially into program RAM from `LOAD_BASE` ($0600). While loading it holds the 6502 in reset and owns the RAM write port. After an idle gap on the serial line it releases the CPU, so a program streamed over serial runs automatically.

## Interface

Parameters:
- `LOAD_BASE`, 16'h0600: address of the first loaded byte.
- `MAX_LEN`, 16'h0A00: maximum number of bytes accepted per load.
- `IDLE_CYCLES`, 250000: clocks without `rx_valid` that end a load (10 ms at 25 MHz).
- `RST_HOLD`, 16: clocks `cpu_reset_n` stays low after a load ends.

Ports:
- `clk` in 1: system clock (25 MHz). One clock; all logic is on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `rx_valid` in 1: one-cycle strobe, one per received byte.
- `rx_err` in 1: framing error, qualified by `rx_valid`.
- `mem_addr` out 16: RAM write address.
- `mem_wdata` out 8: RAM write data.
- `mem_we` out 1: one-cycle RAM write strobe.
- `loading` out 1: high in LOAD/VEC/RELEASE. The top level muxes the RAM port to the loader while it is high.
- `cpu_reset_n` out 1: CPU reset, active-low.
- `load_len` out 16: bytes written in the current or last load.
- `load_err` out 1: sticky error for the current load.

## Operation

States: WAIT, LOAD, VEC (only with `LOADER_VECTOR_EN`), RELEASE, RUN.

- WAIT (reset state):
  - `cpu_reset_n`=0, `loading`=0.
  - `rx_valid` → LOAD and start a new load.
- Start of a new load:
  - `load_len` and `load_err` cleared, pointer = `LOAD_BASE`.
  - The triggering byte is processed as a LOAD byte.
- LOAD, on each `rx_valid`:
  - `rx_err`=1 → byte dropped, `load_err` set, pointer unchanged.
  - `load_len` == `MAX_LEN` → byte dropped, `load_err` set.
  - Otherwise → write `rx_data` to pointer, pointer+1, `load_len`+1.
- LOAD idle timeout:
  - Idle counter clears on every `rx_valid` and increments otherwise.
  - Counter reaching `IDLE_CYCLES`-1 → VEC (if enabled), else RELEASE.
- VEC: two writes, then RELEASE (see Configuration).
- RELEASE:
  - Hold counter runs for `RST_HOLD` cycles with `cpu_reset_n`=0.
  - Then → RUN.
- RUN:
  - `cpu_reset_n`=1, `loading`=0.
  - `rx_valid` → LOAD and start a new load (reload). `cpu_reset_n` drops in the same cycle the state changes.
- `rx_valid` in VEC or RELEASE: abort to LOAD and start a new load. Any unfinished vector writes are discarded.
- Pointer arithmetic is 16-bit. `MAX_LEN` prevents wrap; `LOAD_BASE`+`MAX_LEN` ≤ $10000 is a parameter constraint.

## Timing

- Reset values:
  - State WAIT, `mem_we`=0, `mem_addr`=`LOAD_BASE`, `mem_wdata`=0.
  - `loading`=0, `cpu_reset_n`=0, `load_len`=0, `load_err`=0.
- `rx_valid` sampled at edge n → `mem_we`=1 with registered `mem_addr`/`mem_wdata` during cycle n+1. Latency is exactly 1; all outputs are registered.
- `load_len` and `load_err` update at the same edge as the write or drop.
- `rx_valid` and the timeout in the same cycle: `rx_valid` wins. The byte is processed, the counter clears, and the state stays LOAD.
- Back-to-back `rx_valid` (every cycle) is supported: one write per cycle.
- Timeout: the last `rx_valid` at edge n → leave LOAD at edge n+`IDLE_CYCLES`.
- RELEASE entered at edge m → `cpu_reset_n`=1 from edge m+`RST_HOLD`.
- `resetn` asserted mid-load: immediate return to reset values. RAM contents are not touched.

## Configuration

- `LOADER_VECTOR_EN` defined:
  - VEC state is compiled in.
  - After the timeout: write `LOAD_BASE`[7:0] to $FFFC in cycle 1, then `LOAD_BASE`[15:8] to $FFFD in cycle 2, then RELEASE.
  - `load_len` does not count vector writes.
- `LOADER_VECTOR_EN` undefined:
  - No VEC state; LOAD → RELEASE directly.
  - The reset vector comes from RAM initialisation.

## Test plan

Bench parameters `IDLE_CYCLES`=1000, `RST_HOLD`=16.

- Reset, then bytes a9 01 8d 00 02 4c 00 06 via `rx_valid` strobes 50 cycles apart → writes $0600..$0607 in order with those values. `load_len`=8, `load_err`=0, `cpu_reset_n` low throughout, and `cpu_reset_n`=1 exactly 1000+16 cycles after the last strobe (plus 2 with `LOADER_VECTOR_EN`, where $FFFC=$00 and $FFFD=$06 are written).
- Same stream with `rx_err`=1 on the 3rd byte → that byte is not written. $0602..$0606 get 00 02 4c 00 06, `load_len`=7, `load_err`=1.
- `MAX_LEN`=4, stream of 6 bytes → only $0600..$0603 written, `load_len`=4, `load_err`=1.
- In RUN, send 2 bytes → `cpu_reset_n` drops at the first strobe. $0600/$0601 are rewritten, `load_len`=2, `load_err` cleared, and the CPU is re-released after the timeout.
- `rx_valid` on the exact timeout cycle → the byte is written and the state stays LOAD. `rx_valid` during RELEASE → return to LOAD with the pointer at $0600.
- `resetn` pulsed low mid-load (after 3 bytes) → all outputs return to reset values immediately. The next byte is written to $0600 with `load_len`=1.
